// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types, frame constants and parity helper for the PS/2 keyboard transmitter
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BIT_HI = 2'd1,
        BIT_LO = 2'd2,
        GAP    = 2'd3
    } ps2_state_e;

    localparam int FRAME_BITS = 11;

    // Parity bit that makes the count of ones across data plus parity odd
    function automatic logic odd_parity(input logic [7:0] data);
        return ~(^data);
    endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// rtl/ps2_byte_fifo.sv - single-clock first-word-fallthrough byte FIFO
module ps2_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] s_tdata,
    input  logic       s_tvalid,
    output logic       s_tready,
    output logic [7:0] m_tdata,
    output logic       m_tvalid,
    input  logic       m_tready
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             ready_q, ready_d;
    logic [7:0]       mem_q [DEPTH];
    logic             push;
    logic             pop;

    // Ready is registered from the count, so a full FIFO refuses a push even when a pop happens in the same cycle
    always_comb begin
        push     = s_tvalid && ready_q;
        pop      = m_tready && (count_q != '0);
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
        ready_d  = (count_d != FULL_COUNT);
    end

    // Pointer, count and ready state; ready stays low while reset is held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
        end
    end

    // Storage array; contents are don't-care until written so it carries no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_tdata;
        end
    end

    assign s_tready = ready_q;
    assign m_tdata  = mem_q[rd_ptr_q];
    assign m_tvalid = (count_q != '0);

endmodule

// File: rtl/ps2_kbd_tx.sv
// rtl/ps2_kbd_tx.sv - PS/2 keyboard-side frame transmitter with byte FIFO and host inhibit handling
module ps2_kbd_tx
    import ps2_pkg::*;
#(
    parameter int CLK_DIV    = 2500,
    parameter int GAP_CYCLES = 5000,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       N_RESET,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       byte_ready,
    input  logic       ps2_clk_in,
    output logic       ps2Clk,
    output logic       ps2Data,
    output logic       busy
);

    localparam int MAX_DIV = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int CNT_W   = $clog2(MAX_DIV) + 1;
    localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_RELOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [3:0]       LAST_IDX    = 4'(FRAME_BITS - 1);

    ps2_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_idx_q, bit_idx_d;
    logic [9:0]       shift_q, shift_d;
    logic             ps2_clk_q, ps2_clk_d;
    logic             ps2_data_q, ps2_data_d;
    logic [1:0]       sync_q, sync_d;
    logic [7:0]       head_byte;
    logic             head_valid;
    logic             fifo_pop;
    logic             host_clk;

    ps2_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (N_RESET),
        .s_tdata  (byte_in),
        .s_tvalid (byte_valid),
        .s_tready (byte_ready),
        .m_tdata  (head_byte),
        .m_tvalid (head_valid),
        .m_tready (fifo_pop)
    );

    assign host_clk = sync_q[1];

    // Next-state logic: the shift register holds the bits still to send after the current one;
    // the head byte is popped only once its stop bit finishes, so an aborted frame is retried
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        ps2_clk_d  = ps2_clk_q;
        ps2_data_d = ps2_data_q;
        sync_d     = {sync_q[0], ps2_clk_in};
        fifo_pop   = 1'b0;
        case (state_q)
            IDLE: begin
                if (head_valid && host_clk) begin
                    state_d    = BIT_HI;
                    cnt_d      = HALF_RELOAD;
                    bit_idx_d  = 4'd0;
                    shift_d    = {1'b1, odd_parity(head_byte), head_byte};
                    ps2_clk_d  = 1'b1;
                    ps2_data_d = 1'b0;
                end
            end
            BIT_HI: begin
                if (!host_clk && (bit_idx_q != LAST_IDX)) begin
                    state_d    = GAP;
                    cnt_d      = GAP_RELOAD;
                    ps2_clk_d  = 1'b1;
                    ps2_data_d = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d   = BIT_LO;
                    cnt_d     = HALF_RELOAD;
                    ps2_clk_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            BIT_LO: begin
                if (cnt_q == '0) begin
                    if (bit_idx_q == LAST_IDX) begin
                        state_d    = GAP;
                        cnt_d      = GAP_RELOAD;
                        ps2_clk_d  = 1'b1;
                        ps2_data_d = 1'b1;
                        fifo_pop   = 1'b1;
                    end else begin
                        state_d    = BIT_HI;
                        cnt_d      = HALF_RELOAD;
                        bit_idx_d  = bit_idx_q + 4'd1;
                        ps2_data_d = shift_q[0];
                        shift_d    = {1'b1, shift_q[9:1]};
                        ps2_clk_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d    = IDLE;
                cnt_d      = '0;
                ps2_clk_d  = 1'b1;
                ps2_data_d = 1'b1;
            end
        endcase
    end

    // FSM, divider, shift register, registered line outputs and host-clock synchronizer
    always_ff @(posedge clk or negedge N_RESET) begin
        if (!N_RESET) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= 4'd0;
            shift_q    <= '1;
            ps2_clk_q  <= 1'b1;
            ps2_data_q <= 1'b1;
            sync_q     <= 2'b11;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            ps2_clk_q  <= ps2_clk_d;
            ps2_data_q <= ps2_data_d;
            sync_q     <= sync_d;
        end
    end

    assign ps2Clk  = ps2_clk_q;
    assign ps2Data = ps2_data_q;
    assign busy    = (state_q != IDLE) || head_valid;

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// tb/tb_ps2_kbd_tx.sv - directed self-checking bench for ps2_kbd_tx
module tb_ps2_kbd_tx;

    logic       clk = 1'b0;
    logic       N_RESET;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;
    logic       ps2_clk_in;
    logic       ps2Clk;
    logic       ps2Data;
    logic       busy;

    int n_cmp  = 0;
    int n_fail = 0;

    logic falls[$];
    logic prev_clk = 1'b1;

    ps2_kbd_tx #(
        .CLK_DIV    (4),
        .GAP_CYCLES (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .N_RESET    (N_RESET),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .ps2_clk_in (ps2_clk_in),
        .ps2Clk     (ps2Clk),
        .ps2Data    (ps2Data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Record ps2Data at every falling ps2Clk seen on the sampling edge
    always @(negedge clk) begin
        if (prev_clk && !ps2Clk) falls.push_back(ps2Data);
        prev_clk = ps2Clk;
    end

    function automatic logic [10:0] frame_of(input logic [7:0] b);
        return {1'b1, ~(^b), b, 1'b0};
    endfunction

    task automatic push(input logic [7:0] b, output logic acc);
        byte_in    = b;
        byte_valid = 1'b1;
        acc        = byte_ready;
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic wait_falls(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (falls.size() >= n) break;
            @(negedge clk);
        end
        if (falls.size() >= n) ok = 1'b1;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        if (!busy) ok = 1'b1;
    endtask

    function automatic logic [10:0] grab(input int base);
        logic [10:0] v;
        v = '0;
        for (int i = 0; i < 11; i++) v[i] = falls[base + i];
        return v;
    endfunction

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_cmp++; if (ps2Clk !== 1'b1) begin n_fail++; $display("FAIL reset_ps2clk got %b want 1", ps2Clk); end
        n_cmp++; if (ps2Data !== 1'b1) begin n_fail++; $display("FAIL reset_ps2data got %b want 1", ps2Data); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (byte_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", byte_ready); end
        N_RESET = 1'b1;
        @(negedge clk);
        n_cmp++; if (byte_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready got %b want 1", byte_ready); end
    endtask

    task automatic test_single;
        logic acc;
        int   len;
        bit   ok;
        falls.delete();
        push(8'h1C, acc);
        n_cmp++; if (acc !== 1'b1) begin n_fail++; $display("FAIL single_accept got %b want 1", acc); end
        n_cmp++; if (ps2Data !== 1'b1) begin n_fail++; $display("FAIL single_early_start got %b want 1", ps2Data); end
        @(negedge clk);
        n_cmp++; if (ps2Data !== 1'b0) begin n_fail++; $display("FAIL single_start_edge got %b want 0", ps2Data); end
        len = 1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (falls.size() >= 11 && ps2Clk) break;
            len++;
        end
        n_cmp++; if (len != 88) begin n_fail++; $display("FAIL single_length got %0d want 88", len); end
        n_cmp++; if (falls.size() != 11) begin n_fail++; $display("FAIL single_fall_count got %0d want 11", falls.size()); end
        if (falls.size() >= 11) begin
            n_cmp++; if (grab(0) !== 11'b100_0011_1000) begin n_fail++; $display("FAIL single_bits got %b want 10000111000", grab(0)); end
        end
        wait_idle(100, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL single_idle got busy=%b want 0", busy); end
    endtask

    task automatic test_back_to_back;
        logic a0, a1;
        int   gap;
        bit   ok;
        falls.delete();
        push(8'hF0, a0);
        push(8'h1C, a1);
        n_cmp++; if ({a0, a1} !== 2'b11) begin n_fail++; $display("FAIL b2b_accept got %b want 11", {a0, a1}); end
        wait_falls(11, 200, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL b2b_first_frame got %0d falls want 11", falls.size()); end
        gap = 0;
        for (int i = 0; i < 60; i++) begin
            if (ps2Clk && ps2Data) gap++;
            else if (gap > 0) break;
            @(negedge clk);
        end
        n_cmp++; if (gap < 8) begin n_fail++; $display("FAIL b2b_gap got %0d want >=8", gap); end
        wait_falls(22, 200, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL b2b_second_frame got %0d falls want 22", falls.size()); end
        if (ok) begin
            n_cmp++; if (grab(0) !== 11'b111_1110_0000) begin n_fail++; $display("FAIL b2b_bits_f0 got %b want 11111100000", grab(0)); end
            n_cmp++; if (grab(11) !== 11'b100_0011_1000) begin n_fail++; $display("FAIL b2b_bits_1c got %b want 10000111000", grab(11)); end
        end
        wait_idle(100, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL b2b_idle got busy=%b want 0", busy); end
    endtask

    task automatic test_fifo_full;
        logic [7:0] bytes [5];
        logic [4:0] acc;
        logic       a;
        bit         ok;
        bit         quiet;
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        ps2_clk_in = 1'b0;
        repeat (3) @(negedge clk);
        falls.delete();
        for (int i = 0; i < 5; i++) begin
            push(bytes[i], a);
            acc[i] = a;
        end
        n_cmp++; if (acc !== 5'b01111) begin n_fail++; $display("FAIL full_accepts got %b want 01111", acc); end
        n_cmp++; if (byte_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got %b want 0", byte_ready); end
        quiet = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (!ps2Clk || !ps2Data) quiet = 1'b0;
            @(negedge clk);
        end
        n_cmp++; if (!quiet || falls.size() != 0) begin n_fail++; $display("FAIL full_inhibit_lines got quiet=%b falls=%0d want 1/0", quiet, falls.size()); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL full_busy got %b want 1", busy); end
        ps2_clk_in = 1'b1;
        wait_falls(44, 700, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL full_drain got %0d falls want 44", falls.size()); end
        if (ok) begin
            for (int f = 0; f < 4; f++) begin
                n_cmp++; if (grab(f * 11) !== frame_of(bytes[f])) begin n_fail++; $display("FAIL full_frame%0d got %b want %b", f, grab(f * 11), frame_of(bytes[f])); end
            end
        end
        wait_idle(100, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL full_idle got busy=%b want 0", busy); end
        n_cmp++; if (falls.size() != 44) begin n_fail++; $display("FAIL full_no_fifth got %0d falls want 44", falls.size()); end
    endtask

    task automatic test_abort;
        logic acc;
        bit   ok;
        falls.delete();
        push(8'h55, acc);
        wait_falls(4, 200, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL abort_reach_bit3 got %0d falls want 4", falls.size()); end
        for (int i = 0; i < 20; i++) begin
            if (ps2Clk) break;
            @(negedge clk);
        end
        ps2_clk_in = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if ({ps2Clk, ps2Data} !== 2'b10) begin n_fail++; $display("FAIL abort_before got %b want 10", {ps2Clk, ps2Data}); end
        @(negedge clk);
        n_cmp++; if ({ps2Clk, ps2Data} !== 2'b11) begin n_fail++; $display("FAIL abort_lines got %b want 11", {ps2Clk, ps2Data}); end
        repeat (15) @(negedge clk);
        n_cmp++; if (falls.size() != 4 || busy !== 1'b1) begin n_fail++; $display("FAIL abort_hold got falls=%0d busy=%b want 4/1", falls.size(), busy); end
        falls.delete();
        ps2_clk_in = 1'b1;
        wait_falls(11, 200, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL abort_retry got %0d falls want 11", falls.size()); end
        if (ok) begin
            n_cmp++; if (grab(0) !== 11'b110_1010_1010) begin n_fail++; $display("FAIL abort_bits got %b want 11010101010", grab(0)); end
        end
        wait_idle(100, ok);
        n_cmp++; if (!ok || byte_ready !== 1'b1) begin n_fail++; $display("FAIL abort_idle got busy=%b ready=%b want 0/1", busy, byte_ready); end
        repeat (30) @(negedge clk);
        n_cmp++; if (falls.size() != 11) begin n_fail++; $display("FAIL abort_single_resend got %0d falls want 11", falls.size()); end
    endtask

    task automatic test_reset_mid;
        logic acc;
        bit   ok;
        bit   quiet;
        falls.delete();
        push(8'hAA, acc);
        wait_falls(3, 200, ok);
        n_cmp++; if (!ok || ps2Clk !== 1'b0) begin n_fail++; $display("FAIL rmid_frame got falls=%0d clk=%b want 3/0", falls.size(), ps2Clk); end
        #2;
        N_RESET = 1'b0;
        #1;
        n_cmp++; if ({ps2Clk, ps2Data} !== 2'b11) begin n_fail++; $display("FAIL rmid_async_lines got %b want 11", {ps2Clk, ps2Data}); end
        n_cmp++; if ({busy, byte_ready} !== 2'b00) begin n_fail++; $display("FAIL rmid_async_flags got %b want 00", {busy, byte_ready}); end
        repeat (3) @(negedge clk);
        falls.delete();
        N_RESET = 1'b1;
        @(negedge clk);
        n_cmp++; if (byte_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready got %b want 1", byte_ready); end
        quiet = 1'b1;
        for (int i = 0; i < 150; i++) begin
            if (!ps2Clk || !ps2Data || busy) quiet = 1'b0;
            @(negedge clk);
        end
        n_cmp++; if (!quiet || falls.size() != 0) begin n_fail++; $display("FAIL rmid_no_traffic got quiet=%b falls=%0d want 1/0", quiet, falls.size()); end
    endtask

    initial begin
        N_RESET    = 1'b0;
        ps2_clk_in = 1'b1;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_fifo_full();
        test_abort();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_tx.md
PS2_KBD_TX -- requirements
Module: ps2_kbd_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2500, giving clk cycles per PS/2 clock half-period (10 kHz at 50 MHz).
REQ-002 SHALL have parameter GAP_CYCLES, default 5000, giving the minimum idle clk cycles between frames.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, giving the byte FIFO depth (power of 2, at least 2).
REQ-004 SHALL have port clk, input, 1 bit: single system clock; all logic on its rising edge.
REQ-005 SHALL have port N_RESET, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port byte_in, input, 8 bits: scancode byte to send.
REQ-007 SHALL have port byte_valid, input, 1 bit: byte_in is offered.
REQ-008 SHALL have port byte_ready, output, 1 bit: FIFO not full; a byte is accepted when byte_valid and byte_ready are both high at a clk edge.
REQ-009 SHALL have port ps2_clk_in, input, 1 bit: sensed host clock line; low means inhibit; tie high if unused.
REQ-010 SHALL have port ps2Clk, output, 1 bit: generated PS/2 clock; idles high.
REQ-011 SHALL have port ps2Data, output, 1 bit: generated PS/2 data; idles high.
REQ-012 SHALL have port busy, output, 1 bit: high when the FSM is not in IDLE or the FIFO is non-empty.

Function
REQ-013 SHALL transmit a frame of 11 bits: start bit 0, data bits 0 to 7 (LSB first), odd parity, stop bit 1.
REQ-014 SHALL set the parity bit so that the total count of 1s across data plus parity is odd.
REQ-015 SHALL drive each bit for 2*CLK_DIV cycles: ps2Data changes at the start of the high half (ps2Clk=1, CLK_DIV cycles), then the low half follows (ps2Clk=0, CLK_DIV cycles).
REQ-016 SHALL use FSM states IDLE, BIT_HI, BIT_LO, GAP.
REQ-017 SHALL move IDLE->BIT_HI when the FIFO is non-empty and the synchronized ps2_clk_in is high.
REQ-018 SHALL move BIT_HI->BIT_LO after CLK_DIV cycles.
REQ-019 SHALL move BIT_LO->BIT_HI (next bit) after CLK_DIV cycles, or BIT_LO->GAP after the stop bit.
REQ-020 SHALL move GAP->IDLE after GAP_CYCLES cycles.
REQ-021 SHALL drive the first start-bit edge (ps2Data=0) exactly 2 clk cycles after a byte is accepted into an empty FIFO while idle and uninhibited: one cycle for the FIFO write, one for the FSM.
REQ-022 SHALL pop the FIFO only on BIT_LO->GAP after the stop bit, so that an aborted byte stays at the head.
REQ-023 SHALL synchronize ps2_clk_in with 2 flops before use.
REQ-024 SHALL abort when the synchronized ps2_clk_in is low during BIT_HI of bits 0 to 9: both lines go high next cycle, no pop occurs, the FSM enters GAP, and the same byte is retried from its start bit.
REQ-025 SHALL ignore inhibit during the stop bit; the frame completes.
REQ-026 SHALL block a push when the FIFO is full, even if a pop occurs in the same cycle (byte_ready = not full, registered from count).
REQ-027 SHALL ignore byte_in whenever byte_ready is low.
REQ-028 SHALL wrap FIFO pointers modulo FIFO_DEPTH, with the count register 1 bit wider than the pointers.
REQ-029 SHALL size the divider counter to ceil(log2(max(CLK_DIV, GAP_CYCLES)))+1 bits and reload it at every state change.

Reset
REQ-030 SHALL, while N_RESET is low, immediately force ps2Clk=1, ps2Data=1, busy=0, byte_ready=0, FSM=IDLE, FIFO empty, and counters and synchronizer flops to their idle values (synchronizer flops=1).
REQ-031 SHALL assert byte_ready on the first clk edge after N_RESET is released.
REQ-032 SHALL discard any frame in progress at reset; no partial frame resumes afterwards.

Structure
REQ-033 SHALL place the state enum, FRAME_BITS=11 and the odd-parity function in shared package ps2_pkg.
REQ-034 SHALL implement the FIFO as sub-module ps2_byte_fifo (synchronous, one clock, first-word-fallthrough head output, parameterized depth).
REQ-035 SHALL keep the FSM, divider, bit index (0 to 10) and shift register in ps2_kbd_tx.

Verification (CLK_DIV=4, GAP_CYCLES=8, FIFO_DEPTH=4)
REQ-036 SHALL check: push 0x1C -> ps2Data sampled on each ps2Clk fall = 0,0,0,1,1,1,0,0,0,0,1 (parity 0); frame length 88 cycles; start edge 2 cycles after accept.
REQ-037 SHALL check: push 0xF0 then 0x1C back-to-back -> bits 0,0,0,0,0,1,1,1,1,1,1 then the 0x1C frame; at least 8 idle cycles with both lines high between the frames.
REQ-038 SHALL check: hold ps2_clk_in low, push 5 bytes -> byte_ready low after 4 accepts, 5th byte not accepted, lines stay high; release -> the 4 bytes are sent in order.
REQ-039 SHALL check: pull ps2_clk_in low during BIT_HI of data bit 3 of 0x55 -> lines high next cycle, GAP entered; release -> full 0x55 frame resent, then FIFO empty and busy=0.
REQ-040 SHALL check: assert N_RESET low mid-frame of 0xAA -> ps2Clk=ps2Data=1 with no clk edge needed; after release, no traffic and byte_ready=1 one cycle later.
